// File: rtl/trivium_stream_decrypt.sv
// trivium_stream_decrypt: Trivium keystream unit that XORs each byte of a
// valid/ready byte stream with 8 fresh keystream bits, LSB first. The same
// block encrypts or decrypts, because the operation is a plain XOR.
// Optional build macro: TRIVIUM_STREAM_UNROLL8_EN computes 8 rounds per clock
// instead of one. The keystream sequence and bit order are identical in both
// builds.
module trivium_stream_decrypt #(
  parameter int unsigned WARMUP_CYCLES = 1152
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [79:0] iv,
  output logic        busy,
  output logic        ks_ready,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, RDY, GEN} state_t;

`ifdef TRIVIUM_STREAM_UNROLL8_EN
  localparam int unsigned WARM_STEPS = WARMUP_CYCLES / 8;
`else
  localparam int unsigned WARM_STEPS = WARMUP_CYCLES;
`endif
  localparam logic [10:0] WARM_LAST = 11'(WARM_STEPS - 1);

  // One Trivium round. Bit s(i) of the 1-based state lives at s[i-1].
  // Returns {z, next_state}.
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1, t2, t3;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    return {t1 ^ t2 ^ t3,
            s[286:177], t2 ^ (s[174] & s[175]) ^ s[263],
            s[175:93],  t1 ^ (s[90]  & s[91])  ^ s[170],
            s[91:0],    t3 ^ (s[285] & s[286]) ^ s[68]};
  endfunction

  state_t         state_q, state_d;
  logic [10:0]    cnt_q;
  logic [287:0]   st_q;
  logic [287:0]   st_adv;
  logic [287:0]   st_init;
  logic           accept;
  logic           load_out;
  logic           adv_gen;
  logic [7:0]     out_next;

  // Key in s1..s80, IV in s94..s173, ones in s286..s288, zeros elsewhere.
  assign st_init = {3'b111, 108'd0, 4'd0, iv, 13'd0, key};

  assign busy     = (state_q == LOAD) || (state_q == WARM);
  assign ks_ready = (state_q == RDY)  || (state_q == GEN);
  // A byte arriving together with start belongs to the old key and is dropped.
  assign accept   = in_valid && in_ready && !start;

`ifdef TRIVIUM_STREAM_UNROLL8_EN
  logic [287:0] chain;
  logic [288:0] rnd;
  logic [7:0]   ks_byte;

  // Eight chained rounds per clock; keystream bit k comes from round k.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on entry, so
    // no path through the block can leave it holding and infer a latch.
    chain   = st_q;
    rnd     = '0;
    ks_byte = '0;
    for (int k = 0; k < 8; k++) begin
      rnd        = trivium_round(chain);
      ks_byte[k] = rnd[288];
      chain      = rnd[287:0];
    end
    st_adv = chain;
  end

  assign in_ready = ks_ready && (!out_valid || out_ready);
  assign adv_gen  = accept;
  assign load_out = accept;
  assign out_next = in_data ^ ks_byte;
`else
  logic [288:0] rnd;
  logic         z_bit;
  logic [7:0]   in_byte_q;
  logic [7:0]   pt_q;
  logic [7:0]   gen_byte;

  // Single round per clock; cnt_q[2:0] selects which byte bit is being built.
  always_comb begin
    rnd                     = trivium_round(st_q);
    st_adv                  = rnd[287:0];
    z_bit                   = rnd[288];
    gen_byte                = pt_q;
    gen_byte[cnt_q[2:0]]    = in_byte_q[cnt_q[2:0]] ^ z_bit;
  end

  assign in_ready = (state_q == RDY) && (!out_valid || out_ready);
  assign adv_gen  = (state_q == GEN);
  assign load_out = (state_q == GEN) && (cnt_q[2:0] == 3'd7) && !start;
  assign out_next = gen_byte;

  // Byte under construction: input latched on accept, result built bit by bit.
  always_ff @(posedge clk) begin
    if (accept)           in_byte_q <= in_data;
    if (state_q == GEN)   pt_q      <= gen_byte;
  end
`endif

  // Next-state logic; start from any state forces a reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = IDLE;
      LOAD: state_d = WARM;
      WARM: if (cnt_q == WARM_LAST) state_d = RDY;
`ifdef TRIVIUM_STREAM_UNROLL8_EN
      RDY:  state_d = RDY;
      GEN:  state_d = RDY;
`else
      RDY:  if (accept) state_d = GEN;
      GEN:  if (cnt_q[2:0] == 3'd7) state_d = RDY;
`endif
      default: state_d = IDLE;
    endcase
    if (start) state_d = LOAD;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Round counter: warm-up rounds in WARM, bit index in GEN.
  always_ff @(posedge clk) begin
    if (!rst)                                  cnt_q <= '0;
    else if (state_q == LOAD || accept)        cnt_q <= '0;
    else if (state_q == WARM || state_q == GEN) cnt_q <= cnt_q + 11'd1;
  end

  // Keystream state: loaded in LOAD, advanced only while warming or generating.
  always_ff @(posedge clk) begin
    // NOTE: the 288-bit state has no reset; it is always reloaded in LOAD
    // before it is used, so a reset would only cost routing.
    if (state_q == LOAD)                    st_q <= st_init;
    else if (state_q == WARM || adv_gen)    st_q <= st_adv;
  end

  // Output register: holds under backpressure, cleared by handshake or start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (start) begin
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= out_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
